// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared types, constants and round-robin pick for the UART TX scheduler
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } tx_state_e;

    localparam logic TXD_IDLE  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam int   RR_MAX    = 8;

    // First set bit in valid searching upward from ptr+1 with wrap over n entries.
    function automatic int rr_pick(input logic [RR_MAX-1:0] valid, input int ptr, input int n);
        int         idx;
        logic [2:0] idx3;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 1; i <= RR_MAX; i++) begin
            if (i <= n) begin
                idx  = (ptr + i) % n;
                idx3 = 3'(idx);
                if (!found && valid[idx3]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit down-counter with reload strobe and bit_end flag
module uart_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             bit_end
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign bit_end = en && (cnt == '0);

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin byte arbiter feeding a single UART TX framer with CTS gating
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int DATA_BITS = 8,
    parameter  int DIV_W     = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                           hclk,
    input  logic                           hreset,
    input  logic [DIV_W-1:0]               baud_div,
    input  logic                           parity_en,
    input  logic                           parity_odd,
    input  logic                           two_stop,
    input  logic                           cts_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           txd,
    output logic                           busy,
    output logic [ID_W-1:0]                grant_id
);

    tx_state_e            state, state_next;
    logic                 cts_meta, cts_sync, cts_ok;
    logic                 grant, bit_end, last_bit, timer_load;
    logic [ID_W-1:0]      ptr, winner;
    logic [RR_MAX-1:0]    valid_ext;
    logic [DATA_BITS-1:0] grant_data, shift_q;
    logic [DIV_W-1:0]     div_q, timer_val;
    logic                 par_en_q, par_bit_q, two_stop_q;
    logic [2:0]           bit_cnt;

    // cts_n is asynchronous; idle-high reset keeps the line blocked until synchronized.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts_n;
            cts_sync <= cts_meta;
        end
    end
    assign cts_ok = ~cts_sync;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
        winner                   = ID_W'(rr_pick(valid_ext, int'(ptr), NUM_REQ));
        grant_data               = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) grant_data = req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    assign grant      = (state == IDLE) && cts_ok && (|req_valid);
    assign last_bit   = (bit_cnt == 3'(DATA_BITS - 1));
    assign timer_load = grant || (bit_end && state_next != IDLE);
    assign timer_val  = grant ? baud_div : div_q;

    uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
        .clk      (hclk),
        .rst      (hreset),
        .en       (state != IDLE),
        .load     (timer_load),
        .load_val (timer_val),
        .bit_end  (bit_end)
    );

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant)               state_next = START;
            START:   if (bit_end)             state_next = DATA;
            DATA:    if (bit_end && last_bit) state_next = par_en_q ? PARITY : STOP1;
            PARITY:  if (bit_end)             state_next = STOP1;
            STOP1:   if (bit_end)             state_next = two_stop_q ? STOP2 : IDLE;
            STOP2:   if (bit_end)             state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    always_comb begin
        txd       = TXD_IDLE;
        busy      = 1'b1;
        req_ready = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant) req_ready = NUM_REQ'(1) << winner;
            end
            START:   txd = START_BIT;
            DATA:    txd = shift_q[0];
            PARITY:  txd = par_bit_q;
            default: txd = TXD_IDLE;
        endcase
    end

    // Frame configuration is captured once at grant so inputs may change freely mid-frame.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            div_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            bit_cnt    <= '0;
            grant_id   <= '0;
            ptr        <= ID_W'(NUM_REQ - 1);
        end else if (grant) begin
            div_q      <= baud_div;
            shift_q    <= grant_data;
            par_en_q   <= parity_en;
            par_bit_q  <= (^grant_data) ^ parity_odd;
            two_stop_q <= two_stop;
            bit_cnt    <= '0;
            grant_id   <= winner;
            ptr        <= winner;
        end else if (state == DATA && bit_end) begin
            shift_q    <= shift_q >> 1;
            bit_cnt    <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    localparam int NUM_REQ   = 2;
    localparam int DATA_BITS = 8;
    localparam int DIV_W     = 16;

    logic                         hclk;
    logic                         hreset;
    logic [DIV_W-1:0]             baud_div;
    logic                         parity_en, parity_odd, two_stop, cts_n;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         txd, busy;
    logic [0:0]                   grant_id;

    uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS), .DIV_W(DIV_W)) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .cts_n      (cts_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .txd        (txd),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          div;
        int          gcyc;
    } frame_t;

    frame_t     exp_q[$];
    logic [7:0] pend[NUM_REQ][$];
    logic       cap[$];
    int         cyc, errors, checks, model_ptr, grants, last_grant_cyc, last_len, last_fall;
    int         gid_exp, hw, bad, t0, g;
    bit         gid_chk, cap_active, rr_mode, rr_seen;
    frame_t     fr;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic frame_t make_frame(input logic [7:0] d, input bit pe, input bit po,
                                          input bit ts, input int div, input int gcyc);
        frame_t f;
        int     n;
        f.bits = '0;
        n = 1;
        for (int b = 0; b < DATA_BITS; b++) begin
            f.bits[n] = d[b];
            n = n + 1;
        end
        if (pe) begin
            f.bits[n] = (^d) ^ po;
            n = n + 1;
        end
        f.bits[n] = 1'b1;
        n = n + 1;
        if (ts) begin
            f.bits[n] = 1'b1;
            n = n + 1;
        end
        f.nbits = n;
        f.div   = div;
        f.gcyc  = gcyc;
        return f;
    endfunction

    // Producers: each requester presents the head of its byte queue.
    initial forever begin
        @(posedge hclk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = pend[i].size() > 0;
            req_data[i*DATA_BITS +: DATA_BITS] = (pend[i].size() > 0) ? pend[i][0] : 8'($urandom);
        end
    end

    // Monitor first, then grant handler, so gap and latency checks see a consistent cycle.
    always @(negedge hclk) begin
        if (hreset) begin
            cap_active = 0;
            cap.delete();
            gid_chk = 0;
        end else begin
            if (gid_chk) begin
                check("grant_id", 32'(grant_id), gid_exp);
                check("ready_single_pulse", 32'(req_ready), 0);
                gid_chk = 0;
            end
            if (busy) begin
                if (!cap_active) begin
                    cap_active = 1;
                    cap.delete();
                    if (exp_q.size() > 0) check("start_latency", cyc, exp_q[0].gcyc + 1);
                end
                cap.push_back(txd);
            end else begin
                check("idle_txd", 32'(txd), 1);
                if (cap_active) begin
                    cap_active = 0;
                    last_fall  = cyc;
                    last_len   = cap.size();
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        fr  = exp_q.pop_front();
                        check("frame_len", cap.size(), fr.nbits * (fr.div + 1));
                        bad = -1;
                        for (int k = 0; k < cap.size() && k < fr.nbits * (fr.div + 1); k++) begin
                            if (bad < 0 && cap[k] !== fr.bits[k / (fr.div + 1)]) bad = k;
                        end
                        check("frame_bits_first_bad", bad, 32'hffffffff);
                    end
                end
            end
            if (req_ready != '0) begin
                hw = model_pick(req_valid, model_ptr);
                if (hw < 0) begin
                    check("spurious_ready", 32'(req_ready), 0);
                end else begin
                    check("winner", 32'(req_ready), 1 << hw);
                    if (pend[hw].size() > 0) begin
                        exp_q.push_back(make_frame(pend[hw][0], parity_en, parity_odd, two_stop,
                                                   int'(baud_div), cyc));
                        void'(pend[hw].pop_front());
                    end
                    if (rr_mode && rr_seen) check("rr_one_idle_gap", cyc, last_fall);
                    rr_seen        = 1;
                    model_ptr      = hw;
                    gid_exp        = hw;
                    gid_chk        = 1;
                    last_grant_cyc = cyc;
                    grants++;
                end
            end
        end
    end

    task automatic wait_quiet(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || busy || pend[0].size() != 0 || pend[1].size() != 0) && n < max) begin
            @(negedge hclk);
            n++;
        end
        if (n >= max) check("quiet_timeout", 0, 1);
        @(negedge hclk);
    endtask

    task automatic wait_grant(input int g0, input int max);
        int n = 0;
        while (grants == g0 && n < max) begin
            @(negedge hclk);
            n++;
        end
        if (n >= max) check("grant_timeout", 0, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        hreset = 1'b1; cts_n = 1'b0; baud_div = 16'd3;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        req_valid = '0; req_data = '0;
        model_ptr = NUM_REQ - 1;
        pend[0].push_back(8'hA5);

        repeat (5) begin
            @(negedge hclk);
            check("rst_txd", 32'(txd), 1);
            check("rst_ready", 32'(req_ready), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_grant_id", 32'(grant_id), 0);
        end
        @(posedge hclk); #1;
        hreset = 1'b0;
        t0 = cyc;
        wait_grant(0, 20);
        check("first_grant_delay", last_grant_cyc - t0, 2);
        wait_quiet(200);
        check("basic_len", last_len, 40);

        parity_en = 1'b1; two_stop = 1'b1;
        for (int odd = 0; odd < 2; odd++) begin
            parity_odd = odd[0];
            pend[0].push_back(8'hA5);
            wait_quiet(200);
            check("parity_len", last_len, 48);
        end

        parity_en = 1'b0; two_stop = 1'b0; baud_div = 16'd0;
        rr_mode = 1; rr_seen = 0; g = grants;
        for (int k = 0; k < 4; k++) begin
            pend[0].push_back(8'h11);
            pend[1].push_back(8'h22);
        end
        wait_quiet(300);
        check("rr_grant_count", grants - g, 8);
        rr_mode = 0;

        baud_div = 16'd3;
        @(posedge hclk); #1;
        cts_n = 1'b1;
        repeat (4) @(posedge hclk);
        #1;
        g = grants;
        pend[0].push_back(8'h3C);
        repeat (10) begin
            @(negedge hclk);
            check("cts_block_ready", 32'(req_ready), 0);
        end
        @(posedge hclk); #1;
        cts_n = 1'b0;
        t0 = cyc;
        wait_grant(g, 20);
        check("cts_grant_delay_2_to_3", ((last_grant_cyc - t0) >= 2) && ((last_grant_cyc - t0) <= 3), 1);
        repeat (8) @(posedge hclk);
        #1;
        cts_n = 1'b1;
        pend[0].push_back(8'hC3);
        repeat (60) @(negedge hclk);
        check("cts_no_regrant", grants, g + 1);
        pend[0].delete();
        @(posedge hclk); #1;
        cts_n = 1'b0;
        repeat (10) @(negedge hclk);
        check("withdraw_no_grant", grants, g + 1);

        for (int r = 0; r < 20; r++) begin
            baud_div   = 16'($urandom_range(0, 3));
            parity_en  = 1'($urandom);
            parity_odd = 1'($urandom);
            two_stop   = 1'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                repeat ($urandom_range(0, 3)) pend[i].push_back(8'($urandom));
            end
            wait_quiet(2000);
        end

        baud_div = 16'd3; parity_en = 1'b0; two_stop = 1'b0;
        g = grants;
        pend[0].push_back(8'h96);
        wait_grant(g, 20);
        repeat (14) @(posedge hclk);
        #1;
        hreset = 1'b1;
        #1;
        check("midframe_rst_txd", 32'(txd), 1);
        check("midframe_rst_busy", 32'(busy), 0);
        @(negedge hclk);
        exp_q.delete();
        model_ptr = NUM_REQ - 1;
        pend[0].push_back(8'h96);
        repeat (2) @(posedge hclk);
        #1;
        hreset = 1'b0;
        wait_grant(g + 1, 20);
        wait_quiet(200);
        check("regrant_len", last_len, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
